// File: rtl/riscv_32i_lsu.sv
// RV32I load/store unit: one outstanding request, word-aligned memory port with byte enables.
// Optional macro RISCV_LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into error responses.

package riscv_32i_defs_pkg;
    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] word_t;
    typedef logic [7:0]      byte_t;
endpackage

module riscv_32i_lsu
    import riscv_32i_defs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  word_t       req_addr,
    input  word_t       req_wdata,
    output logic        rsp_valid,
    output word_t       rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output word_t       mem_addr,
    output logic [3:0]  mem_be,
    output word_t       mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  word_t       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [2:0]           funct3_q, funct3_d;
    word_t                addr_q, addr_d;
    word_t                wdata_q, wdata_d;
    word_t                rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic       illegal;
    logic       misaligned;
    logic       expired;
    logic [1:0] off;
    logic [3:0] be;
    word_t      store_data;
    byte_t      lane_b;
    logic [15:0] lane_h;
    word_t      load_data;

    assign illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign expired = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign off     = addr_q[1:0];

    // Halfwords only ever use off[1] and words ignore the offset, which silently aligns them.
    always_comb begin
        be         = 4'b1111;
        store_data = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be         = 4'b0001 << off;
                store_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be         = off[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane_b = mem_rdata[{off, 3'b000} +: 8];
    assign lane_h = mem_rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_data = {24'd0, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_data = {16'd0, lane_h};
            default: load_data = mem_rdata;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    cnt_d    = '0;
                    if (illegal || misaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = we_q ? RESP : MEM_WAIT;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = load_data;
                    state_d = RESP;
                end else if (expired) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_req   = (state_q == MEM_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem_be    = mem_req ? be : 4'b0000;
    assign mem_wdata = mem_req ? store_data : '0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid & err_q;

endmodule
